// File: rtl/bank_timing_tracker.sv
// bank_timing_tracker: per-bank DDR4 state and timing tracker for the memory model.
// Decodes {bg, ba} into a flat bank index and runs one small state machine per bank.
// Each bank has a phase timer (tRCD / tRP / tRFC, one per transient state), plus
// independent tRAS and tWR down-counters. Illegal or early commands are flagged
// with a registered cmd_err pulse and change no state.
// Optional feature: define BANK_ERR_COUNT_EN to build a saturating 16-bit
// rejected-command counter on err_count; otherwise err_count is tied to 0.
module bank_timing_tracker #(
    parameter int BGWIDTH = 2,
    parameter int BAWIDTH = 2,
    parameter int CNTW    = 8,
    parameter int TRCD    = 14,
    parameter int TRP     = 14,
    parameter int TRAS    = 32,
    parameter int TWR     = 16,
    parameter int TRFC    = 64
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic                                       cmd_valid,
    input  logic [3:0]                                 cmd,
    input  logic [BGWIDTH-1:0]                         bg,
    input  logic [BAWIDTH-1:0]                         ba,
    output logic                                       cmd_ok,
    output logic                                       cmd_err,
    output logic [3*(2**(BGWIDTH+BAWIDTH))-1:0]        bank_state,
    output logic [(2**(BGWIDTH+BAWIDTH))-1:0]          bank_ready,
    output logic                                       all_idle,
    output logic [15:0]                                err_count
);

    localparam int IDXW   = BGWIDTH + BAWIDTH;
    localparam int NBANKS = 2**IDXW;

    // Phase timer load values. A transient state is left when the timer is at 1,
    // so loading T-1 at the command edge makes the next state visible at c+T.
    localparam logic [CNTW-1:0] TRCD_LD = CNTW'(TRCD - 1);
    localparam logic [CNTW-1:0] TRP_LD  = CNTW'(TRP - 1);
    localparam logic [CNTW-1:0] TRFC_LD = CNTW'(TRFC - 1);
    localparam logic [CNTW-1:0] TRAS_LD = CNTW'(TRAS - 1);
    localparam logic [CNTW-1:0] TWR_LD  = CNTW'(TWR - 1);
    // Auto-precharge enters PRECHARGING one edge "early" (when the counters are
    // about to hit 0), so it needs a full TRP to reach IDLE TRP cycles later.
    localparam logic [CNTW-1:0] TRP_AP  = CNTW'(TRP);
    localparam logic [CNTW-1:0] ONE     = CNTW'(1);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ACTIVATING  = 3'd1,
        ST_ACTIVE      = 3'd2,
        ST_PRECHARGING = 3'd3,
        ST_REFRESHING  = 3'd4
    } bank_st_e;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ACT = 4'd1,
        CMD_RD  = 4'd2,
        CMD_RDA = 4'd3,
        CMD_WR  = 4'd4,
        CMD_WRA = 4'd5,
        CMD_PR  = 4'd6,
        CMD_PRA = 4'd7,
        CMD_REF = 4'd8
    } cmd_e;

    bank_st_e            state_q [NBANKS];
    bank_st_e            state_d [NBANKS];
    logic [CNTW-1:0]     tmr_q   [NBANKS];
    logic [CNTW-1:0]     tmr_d   [NBANKS];
    logic [CNTW-1:0]     tras_q  [NBANKS];
    logic [CNTW-1:0]     tras_d  [NBANKS];
    logic [CNTW-1:0]     twr_q   [NBANKS];
    logic [CNTW-1:0]     twr_d   [NBANKS];
    logic [NBANKS-1:0]   ap_q;
    logic [NBANKS-1:0]   ap_d;

    logic                cmd_ok_q, cmd_ok_d;
    logic                cmd_err_q, cmd_err_d;
    logic [IDXW-1:0]     tgt;
    logic                pra_ok;
    logic                legal;
    logic                issue;

    // Per-bank status outputs and the all-bank conditions used by PRA/REF.
    always_comb begin
        // NOTE: every combinational output gets a default before any conditional
        // assignment, so no path leaves a value unassigned and no latch is inferred.
        all_idle   = 1'b1;
        pra_ok     = 1'b1;
        bank_state = '0;
        bank_ready = '0;
        for (int b = 0; b < NBANKS; b++) begin
            bank_state[b*3 +: 3] = state_q[b];
            if (state_q[b] != ST_IDLE) begin
                all_idle = 1'b0;
            end
            bank_ready[b] = (state_q[b] == ST_IDLE) ||
                            ((state_q[b] == ST_ACTIVE) && (tras_q[b] == '0) && (twr_q[b] == '0));
            if (!((state_q[b] == ST_IDLE) ||
                  ((state_q[b] == ST_ACTIVE) && (tras_q[b] == '0) &&
                   (twr_q[b] == '0) && !ap_q[b]))) begin
                pra_ok = 1'b0;
            end
        end
    end

    // Command legality check against the target bank's current state and timers.
    always_comb begin
        tgt   = {bg, ba};
        legal = 1'b0;
        case (cmd)
            CMD_ACT:                         legal = (state_q[tgt] == ST_IDLE);
            CMD_RD, CMD_RDA, CMD_WR, CMD_WRA: legal = (state_q[tgt] == ST_ACTIVE) && !ap_q[tgt];
            CMD_PR:  legal = (state_q[tgt] == ST_IDLE) ||
                             ((state_q[tgt] == ST_ACTIVE) && (tras_q[tgt] == '0) && (twr_q[tgt] == '0));
            CMD_PRA: legal = pra_ok;
            CMD_REF: legal = all_idle;
            default: legal = 1'b0;
        endcase
        issue     = cmd_valid && (cmd != CMD_NOP);
        cmd_ok_d  = issue && legal;
        cmd_err_d = issue && !legal;
    end

    // Per-bank next state: timer countdowns plus the effect of an accepted command.
    always_comb begin
        for (int b = 0; b < NBANKS; b++) begin
            state_d[b] = state_q[b];
            tmr_d[b]   = tmr_q[b];
            tras_d[b]  = (tras_q[b] == '0) ? '0 : tras_q[b] - ONE;
            twr_d[b]   = (twr_q[b]  == '0) ? '0 : twr_q[b]  - ONE;
            ap_d[b]    = ap_q[b];

            case (state_q[b])
                ST_IDLE: begin
                    if (cmd_ok_d && (cmd == CMD_ACT) && (tgt == IDXW'(b))) begin
                        state_d[b] = (TRCD == 1) ? ST_ACTIVE : ST_ACTIVATING;
                        tmr_d[b]   = TRCD_LD;
                        tras_d[b]  = TRAS_LD;
                    end else if (cmd_ok_d && (cmd == CMD_REF)) begin
                        state_d[b] = (TRFC == 1) ? ST_IDLE : ST_REFRESHING;
                        tmr_d[b]   = TRFC_LD;
                    end
                end
                ST_ACTIVE: begin
                    if (cmd_ok_d && (tgt == IDXW'(b)) && ((cmd == CMD_WR) || (cmd == CMD_WRA))) begin
                        twr_d[b] = TWR_LD;
                    end
                    if (cmd_ok_d && (tgt == IDXW'(b)) && ((cmd == CMD_RDA) || (cmd == CMD_WRA))) begin
                        ap_d[b] = 1'b1;
                    end
                    if (cmd_ok_d && (((cmd == CMD_PR) && (tgt == IDXW'(b))) || (cmd == CMD_PRA))) begin
                        state_d[b] = (TRP == 1) ? ST_IDLE : ST_PRECHARGING;
                        tmr_d[b]   = TRP_LD;
                        ap_d[b]    = 1'b0;
                    end else if (ap_d[b] && (tras_d[b] == '0) && (twr_d[b] == '0)) begin
                        state_d[b] = ST_PRECHARGING;
                        tmr_d[b]   = TRP_AP;
                        ap_d[b]    = 1'b0;
                    end
                end
                ST_ACTIVATING, ST_PRECHARGING, ST_REFRESHING: begin
                    if (tmr_q[b] <= ONE) begin
                        state_d[b] = (state_q[b] == ST_ACTIVATING) ? ST_ACTIVE : ST_IDLE;
                        tmr_d[b]   = '0;
                    end else begin
                        tmr_d[b]   = tmr_q[b] - ONE;
                    end
                end
                default: begin
                    state_d[b] = ST_IDLE;
                    tmr_d[b]   = '0;
                end
            endcase
        end
    end

    // Bank state, timers and the registered accept/reject pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the per-bank arrays are small state registers, not RAM, so they
            // are reset like any flop; a reset mid-operation abandons every timer.
            for (int b = 0; b < NBANKS; b++) begin
                state_q[b] <= ST_IDLE;
                tmr_q[b]   <= '0;
                tras_q[b]  <= '0;
                twr_q[b]   <= '0;
            end
            ap_q      <= '0;
            cmd_ok_q  <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same
            // edge independent of statement order.
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            tras_q    <= tras_d;
            twr_q     <= twr_d;
            ap_q      <= ap_d;
            cmd_ok_q  <= cmd_ok_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign cmd_ok  = cmd_ok_q;
    assign cmd_err = cmd_err_q;

`ifdef BANK_ERR_COUNT_EN
    logic [15:0] err_cnt_q;

    // Saturating count of rejected commands, updated on the edge that raises cmd_err.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
        end else if (cmd_err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: doc/bank_timing_tracker.md
Name: bank_timing_tracker

Overview:
Parametrised per-bank DDR4 state and timing tracker for the memory model. It decodes bank group and bank from each incoming command and runs one state machine per bank. Each bank FSM has real down-counters for tRCD, tRP, tRAS, tWR and tRFC. The block flags illegal or early commands and exposes per-bank state/ready, so the command decoder can reject timing violations.

Parameters:
BGWIDTH, 2, bank-group address width; NBG = 2**BGWIDTH
BAWIDTH, 2, bank address width per group; NBANKS = NBG * 2**BAWIDTH
CNTW, 8, timing counter width; every T* parameter must be less than 2**CNTW
TRCD, 14, ACT to RD/WR, in clk cycles (>=1)
TRP, 14, PR to IDLE, in cycles (>=1)
TRAS, 32, ACT to PR minimum, in cycles (>=1)
TWR, 16, WR to PR minimum, in cycles (>=1)
TRFC, 64, REF to IDLE, in cycles (>=1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present this cycle
cmd  in  4  0 NOP, 1 ACT, 2 RD, 3 RDA, 4 WR, 5 WRA, 6 PR, 7 PRA, 8 REF; others illegal
bg  in  BGWIDTH  target bank group
ba  in  BAWIDTH  target bank
cmd_ok  out  1  registered: previous-cycle command accepted
cmd_err  out  1  registered: previous-cycle command rejected
bank_state  out  3*NBANKS  per-bank state; bank index = bg*2**BAWIDTH + ba
bank_ready  out  NBANKS  bank is IDLE or ACTIVE with no counter running
all_idle  out  1  every bank is IDLE
err_count  out  16  rejected-command count (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): all banks IDLE; all counters and pending flags 0.
  - Outputs after reset: cmd_ok=0, cmd_err=0, bank_ready all 1, all_idle=1, err_count=0.
- Bank state encoding: 0 IDLE, 1 ACTIVATING, 2 ACTIVE, 3 PRECHARGING, 4 REFRESHING.
- At most one command per cycle; no simultaneous-command collisions exist.
- A rejected command changes no state.
- Command issued at cycle c:
  - Accepted: cmd_ok=1 at c+1. Rejected: cmd_err=1 at c+1. Each is a one-cycle pulse.
  - NOP with cmd_valid produces neither pulse.
- ACT: legal only if the target bank is IDLE.
  - ACTIVATING visible at c+1; ACTIVE visible at c+TRCD.
  - Starts the tRAS counter; PR is legal from c+TRAS.
- RD/WR: legal only if the bank is ACTIVE and has no auto-precharge pending.
  - WR (and WRA) reloads the tWR counter; PR is legal from c+TWR.
  - Back-to-back WR restarts tWR.
- RDA/WRA: same legality as RD/WR; sets auto-precharge pending.
  - Bank enters PRECHARGING at the first cycle where tRAS and tWR have both expired, and never before c+1.
  - Bank is IDLE TRP cycles later.
- PR: legal if the bank is IDLE (no-op, accepted) or ACTIVE with tRAS and tWR expired.
  - PRECHARGING visible at c+1; IDLE at c+TRP.
  - PR to ACTIVATING or PRECHARGING banks is rejected.
- PRA: legal only if every bank is IDLE, or ACTIVE with tRAS/tWR expired and no auto-precharge pending.
  - All ACTIVE banks precharge together, as for PR.
- REF: legal only when all_idle=1.
  - All banks REFRESHING at c+1; IDLE at c+TRFC.
- Illegal cmd encodings (9-15) are rejected.
- tRAS and tWR counters saturate at 0. A counter value of 0 means the constraint is met.
- Reset mid-operation (e.g. mid-refresh or mid-precharge) abandons all counters; every bank is IDLE immediately.

Optional Feature:
BANK_ERR_COUNT_EN
- Defined: err_count increments on every cmd_err pulse and saturates at 16'hFFFF; reset clears it.
- Undefined: err_count is tied to 0 and no counter logic is built.

Test Plan:
- ACT bg=1 ba=2 at cycle 0; RD same bank at cycle 13 -> cmd_err=1 at cycle 14. RD at cycle 14 -> cmd_ok=1 at cycle 15; bank_state[6] = ACTIVE from cycle 14.
- ACT at cycle 0, PR at cycle 31 -> cmd_err. PR at cycle 32 -> PRECHARGING at 33, IDLE at 46.
- ACT at 0, WRA at 14 -> bank PRECHARGING at 32, IDLE at 46. RD to that bank at 20 -> cmd_err (auto-precharge pending).
- One bank ACTIVE, REF -> cmd_err, no state change. After PRA and tRP, REF at cycle c -> all banks REFRESHING; all_idle=1 at c+64.
- reset_n low mid-refresh -> all banks IDLE, bank_ready all 1 asynchronously. ACT accepted on the first cycle after release.
- With BANK_ERR_COUNT_EN defined: 3 illegal cmds (encoding 12) -> err_count=3. Forced value 16'hFFFF plus one more error -> stays 16'hFFFF. Without the macro -> err_count=0 throughout.
